trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter DW, default 32, the CSR data and address width (RegBus/MemAddrBus).
REQ-002 SHALL have ports clk, input, 1, the single clock; and rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports ecall_i, ebreak_i and mret_i, input, 1 each, single-cycle decoded-instruction pulses.
REQ-004 SHALL have port inst_addr_i, input, DW, the PC of the instruction currently in decode.
REQ-005 SHALL have ports csr_mtvec_i, csr_mepc_i and csr_mstatus_i, input, DW each, current CSR values.
REQ-006 SHALL have ports timer_int_i and global_int_en_i, input, 1 each, timer request and mstatus.MIE.
REQ-007 SHALL have port wbu_csr_we_i, input, 1, a CSR write from lsu_wbu this cycle; it has priority.
REQ-008 SHALL have port csr_we_o, output, 1, CSR write strobe.
REQ-009 SHALL have ports csr_waddr_o and csr_wdata_o, output, DW each, CSR write address and data.
REQ-010 SHALL have port hold_flag_o, output, 1, pipeline hold request.
REQ-011 SHALL have ports int_assert_o, output, 1, a one-cycle redirect pulse; and int_addr_o, output, DW, the redirect target.

Function
REQ-012 SHALL implement states IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT; MRET path is IDLE->W_MSTATUS->ASSERT.
REQ-013 SHALL in IDLE take at most one event per cycle, priority ecall > ebreak > mret > timer, latching cause code and inst_addr_i.
REQ-014 SHALL take the timer event only when timer_int_i=1 and global_int_en_i=1.
REQ-015 SHALL drive hold_flag_o=1 combinationally in the IDLE cycle an event is taken, and in every non-IDLE state.
REQ-016 SHALL with no stall use trap latency: event at cycle T; writes at T+1 (mepc), T+2 (mstatus), T+3 (mcause); ASSERT at T+4.
REQ-017 SHALL write mepc=latched PC; mcause=11 (ecall), 3 (ebreak) or 0x8000_0007 (timer).
REQ-018 SHALL write mstatus on trap from csr_mstatus_i with MPIE[7]<=MIE[3] and MIE[3]<=0, other bits unchanged.
REQ-019 SHALL write mstatus on mret with MIE[3]<=MPIE[7] and MPIE[7]<=1.
REQ-020 SHALL use CSR addresses mstatus 0x300, mepc 0x341, mcause 0x342; upper address bits 0.
REQ-021 SHALL in ASSERT drive int_assert_o=1 for exactly one cycle, int_addr_o=csr_mtvec_i (trap) or csr_mepc_i (mret), then go to IDLE.
REQ-022 SHALL, when wbu_csr_we_i=1 in a write state, drive csr_we_o=0 and stay in that state (retry next cycle, no lost write).
REQ-023 SHALL ignore events arriving in non-IDLE states.
REQ-024 SHALL drive csr_we_o, int_assert_o, csr_waddr_o, csr_wdata_o and int_addr_o at 0 whenever not writing or asserting.

Reset
REQ-025 SHALL on rst_n=0 enter IDLE at once, with all outputs 0 and latched cause/PC 0.
REQ-026 SHALL, on reset mid-sequence, perform no further CSR writes; writes already done stand.

Configuration
REQ-027 SHALL, when TRAP_CTRL_TIMER_INT_EN is defined, implement the timer path per REQ-014.
REQ-028 SHALL, when TRAP_CTRL_TIMER_INT_EN is undefined, ignore timer_int_i and global_int_en_i; only ecall/ebreak/mret are handled.

Structure
REQ-029 SHALL place CSR addresses, cause codes and state encodings in shared defines.v.
REQ-030 SHALL place the event priority encoder in one sub-module, trap_prio_enc (combinational); everything else stays in trap_ctrl.

Verification
REQ-031 SHALL cover: ecall_i pulse, inst_addr_i=0x8000_0010, mstatus=0x8, mtvec=0x8000_0100 -> writes 0x341=0x8000_0010, 0x300=0x80, 0x342=11; int_assert_o at T+4 with int_addr_o=0x8000_0100.
REQ-032 SHALL cover: mret_i with mstatus=0x80, mepc=0x8000_0014 -> write 0x300=0x88 at T+1; int_addr_o=0x8000_0014 at T+2.
REQ-033 SHALL cover: ecall_i and timer_int_i together with global_int_en_i=1 -> mcause=11, timer not taken; then with MIE=1 the timer is taken, mcause=0x8000_0007.
REQ-034 SHALL cover: wbu_csr_we_i=1 for 2 cycles during W_MSTATUS -> csr_we_o low for 2 cycles, the write occurs on the 3rd, ASSERT is delayed by 2.
REQ-035 SHALL cover: rst_n low in W_MSTATUS -> outputs 0 at once; after release, no mstatus/mcause write occurs and the state is IDLE.
REQ-036 SHALL cover: timer_int_i=1 with global_int_en_i=0, or TRAP_CTRL_TIMER_INT_EN undefined -> no hold, no writes.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// rtl/trap_ctrl_pkg.sv - shared CSR addresses, cause codes and state encodings for trap_ctrl
package trap_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_MEPC,
        ST_W_MSTATUS,
        ST_W_MCAUSE,
        ST_ASSERT
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_ECALL,
        EV_EBREAK,
        EV_MRET,
        EV_TIMER
    } event_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] CAUSE_ECALL  = 32'd11;
    localparam logic [31:0] CAUSE_EBREAK = 32'd3;
    localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;

    function automatic logic [31:0] cause_code(input event_e ev);
        case (ev)
            EV_ECALL:  return CAUSE_ECALL;
            EV_EBREAK: return CAUSE_EBREAK;
            EV_TIMER:  return CAUSE_TIMER;
            default:   return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// rtl/trap_prio_enc.sv - picks one trap event per cycle: ecall > ebreak > mret > timer
module trap_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic   ecall_i,
    input  logic   ebreak_i,
    input  logic   mret_i,
    input  logic   timer_i,
    output event_e ev_o
);

    always_comb begin
        ev_o = EV_NONE;
        if (ecall_i)       ev_o = EV_ECALL;
        else if (ebreak_i) ev_o = EV_EBREAK;
        else if (mret_i)   ev_o = EV_MRET;
        else if (timer_i)  ev_o = EV_TIMER;
    end

endmodule

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - trap/mret sequencer writing mepc/mstatus/mcause then redirecting the PC
// Timer interrupt path is built only when TRAP_CTRL_TIMER_INT_EN is defined.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ecall_i,
    input  logic          ebreak_i,
    input  logic          mret_i,
    input  logic [DW-1:0] inst_addr_i,
    input  logic [DW-1:0] csr_mtvec_i,
    input  logic [DW-1:0] csr_mepc_i,
    input  logic [DW-1:0] csr_mstatus_i,
    input  logic          timer_int_i,
    input  logic          global_int_en_i,
    input  logic          wbu_csr_we_i,
    output logic          csr_we_o,
    output logic [DW-1:0] csr_waddr_o,
    output logic [DW-1:0] csr_wdata_o,
    output logic          hold_flag_o,
    output logic          int_assert_o,
    output logic [DW-1:0] int_addr_o
);

    state_e        state_q, state_d;
    event_e        cause_q, cause_d;
    logic [DW-1:0] pc_q, pc_d;
    event_e        ev;
    logic          timer_req;
    logic [DW-1:0] mstatus_trap, mstatus_mret;

`ifdef TRAP_CTRL_TIMER_INT_EN
    assign timer_req = timer_int_i & global_int_en_i;
`else
    logic unused_timer;
    assign unused_timer = timer_int_i ^ global_int_en_i;
    assign timer_req    = 1'b0;
`endif

    trap_prio_enc u_prio_enc (
        .ecall_i (ecall_i),
        .ebreak_i(ebreak_i),
        .mret_i  (mret_i),
        .timer_i (timer_req),
        .ev_o    (ev)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cause_q <= EV_NONE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
        end
    end

    // A write state only advances once lsu_wbu leaves the CSR port free.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        case (state_q)
            ST_IDLE: begin
                if (ev != EV_NONE) begin
                    cause_d = ev;
                    pc_d    = inst_addr_i;
                    state_d = (ev == EV_MRET) ? ST_W_MSTATUS : ST_W_MEPC;
                end
            end
            ST_W_MEPC:    if (!wbu_csr_we_i) state_d = ST_W_MSTATUS;
            ST_W_MSTATUS: if (!wbu_csr_we_i) state_d = (cause_q == EV_MRET) ? ST_ASSERT : ST_W_MCAUSE;
            ST_W_MCAUSE:  if (!wbu_csr_we_i) state_d = ST_ASSERT;
            ST_ASSERT:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mstatus_trap               = csr_mstatus_i;
        mstatus_trap[MSTATUS_MPIE] = csr_mstatus_i[MSTATUS_MIE];
        mstatus_trap[MSTATUS_MIE]  = 1'b0;
        mstatus_mret               = csr_mstatus_i;
        mstatus_mret[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
        mstatus_mret[MSTATUS_MPIE] = 1'b1;
    end

    always_comb begin
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_flag_o  = (state_q != ST_IDLE) || (ev != EV_NONE);
        case (state_q)
            ST_W_MEPC: if (!wbu_csr_we_i) begin
                csr_we_o    = 1'b1;
                csr_waddr_o = DW'(CSR_MEPC);
                csr_wdata_o = pc_q;
            end
            ST_W_MSTATUS: if (!wbu_csr_we_i) begin
                csr_we_o    = 1'b1;
                csr_waddr_o = DW'(CSR_MSTATUS);
                csr_wdata_o = (cause_q == EV_MRET) ? mstatus_mret : mstatus_trap;
            end
            ST_W_MCAUSE: if (!wbu_csr_we_i) begin
                csr_we_o    = 1'b1;
                csr_waddr_o = DW'(CSR_MCAUSE);
                csr_wdata_o = DW'(cause_code(cause_q));
            end
            ST_ASSERT: begin
                int_assert_o = 1'b1;
                int_addr_o   = (cause_q == EV_MRET) ? csr_mepc_i : csr_mtvec_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - per-cycle vector table plus reset sequence for trap_ctrl
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ecall_i, ebreak_i, mret_i, timer_int_i, global_int_en_i, wbu_csr_we_i;
    logic [31:0] inst_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic        csr_we_o, hold_flag_o, int_assert_o;
    logic [31:0] csr_waddr_o, csr_wdata_o, int_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ecall_i        (ecall_i),
        .ebreak_i       (ebreak_i),
        .mret_i         (mret_i),
        .inst_addr_i    (inst_addr_i),
        .csr_mtvec_i    (csr_mtvec_i),
        .csr_mepc_i     (csr_mepc_i),
        .csr_mstatus_i  (csr_mstatus_i),
        .timer_int_i    (timer_int_i),
        .global_int_en_i(global_int_en_i),
        .wbu_csr_we_i   (wbu_csr_we_i),
        .csr_we_o       (csr_we_o),
        .csr_waddr_o    (csr_waddr_o),
        .csr_wdata_o    (csr_wdata_o),
        .hold_flag_o    (hold_flag_o),
        .int_assert_o   (int_assert_o),
        .int_addr_o     (int_addr_o)
    );

    typedef struct {
        logic        ec, eb, mr, ti, ge, wb;
        logic [31:0] pc, ms, tv, ep;
        logic        hold, we;
        logic [31:0] wa, wd;
        logic        as;
        logic [31:0] ia;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] cur_pc, cur_ms, cur_tv, cur_ep;

    task automatic add(input logic ec, eb, mr, ti, ge, wb,
                       input logic hold, we, input logic [31:0] wa, wd,
                       input logic as, input logic [31:0] ia);
        vec_t r;
        r.ec = ec; r.eb = eb; r.mr = mr; r.ti = ti; r.ge = ge; r.wb = wb;
        r.pc = cur_pc; r.ms = cur_ms; r.tv = cur_tv; r.ep = cur_ep;
        r.hold = hold; r.we = we; r.wa = wa; r.wd = wd; r.as = as; r.ia = ia;
        tbl.push_back(r);
    endtask

    task automatic scenario(input logic [31:0] pc, ms, tv, ep);
        cur_pc = pc; cur_ms = ms; cur_tv = tv; cur_ep = ep;
    endtask

    task automatic check(input string name, input logic [98:0] act, input logic [98:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got hold/we/waddr/wdata/assert/iaddr=%h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [98:0] outs();
        return {hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o};
    endfunction

    task automatic idle_inputs();
        ecall_i = 0; ebreak_i = 0; mret_i = 0; timer_int_i = 0;
        global_int_en_i = 0; wbu_csr_we_i = 0;
    endtask

    initial begin
        idle_inputs();
        inst_addr_i = 0; csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;
        rst_n = 1'b0;

        // ecall with MIE=1; an ebreak during W_MCAUSE must be ignored
        scenario(32'h8000_0010, 32'h8, 32'h8000_0100, 32'h0);
        add(1,0,0,0,0,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h341,32'h8000_0010,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h300,32'h80,0,32'h0);
        add(0,1,0,0,0,0, 1,1,32'h342,32'd11,0,32'h0);
        add(0,0,0,0,0,0, 1,0,32'h0,32'h0,1,32'h8000_0100);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);
        // mret
        scenario(32'h40, 32'h80, 32'h100, 32'h8000_0014);
        add(0,0,1,0,0,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h300,32'h88,0,32'h0);
        add(0,0,0,0,0,0, 1,0,32'h0,32'h0,1,32'h8000_0014);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);
        // ebreak beats mret
        scenario(32'h1234, 32'h88, 32'h100, 32'h999);
        add(0,1,1,0,0,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h341,32'h1234,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h300,32'h80,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h342,32'd3,0,32'h0);
        add(0,0,0,0,0,0, 1,0,32'h0,32'h0,1,32'h100);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);
        // ecall beats timer; timer held high stays ignored until back in IDLE
        scenario(32'h500, 32'h8, 32'h100, 32'h0);
        add(1,0,0,1,1,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,1,1,0, 1,1,32'h341,32'h500,0,32'h0);
        add(0,0,0,1,1,0, 1,1,32'h300,32'h80,0,32'h0);
        add(0,0,0,1,1,0, 1,1,32'h342,32'd11,0,32'h0);
        add(0,0,0,1,1,0, 1,0,32'h0,32'h0,1,32'h100);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);
        // lsu_wbu owns the CSR port for 2 cycles in W_MSTATUS
        scenario(32'h600, 32'h1808, 32'h100, 32'h0);
        add(1,0,0,0,0,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h341,32'h600,0,32'h0);
        add(0,0,0,0,0,1, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,1, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h300,32'h1880,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h342,32'd11,0,32'h0);
        add(0,0,0,0,0,0, 1,0,32'h0,32'h0,1,32'h100);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);
        // timer with global enable off: nothing happens
        scenario(32'h700, 32'h8, 32'h100, 32'h0);
        add(0,0,0,1,0,0, 0,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,1,0,0, 0,0,32'h0,32'h0,0,32'h0);
`ifdef TRAP_CTRL_TIMER_INT_EN
        add(0,0,0,1,1,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h341,32'h700,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h300,32'h80,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h342,32'h8000_0007,0,32'h0);
        add(0,0,0,0,0,0, 1,0,32'h0,32'h0,1,32'h100);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);
`else
        add(0,0,0,1,1,0, 0,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,1,1,0, 0,0,32'h0,32'h0,0,32'h0);
`endif
        // all three instruction events at once: ecall wins
        scenario(32'h800, 32'h0, 32'h100, 32'h0);
        add(1,1,1,0,0,0, 1,0,32'h0,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h341,32'h800,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h300,32'h0,0,32'h0);
        add(0,0,0,0,0,0, 1,1,32'h342,32'd11,0,32'h0);
        add(0,0,0,0,0,0, 1,0,32'h0,32'h0,1,32'h100);
        add(0,0,0,0,0,0, 0,0,32'h0,32'h0,0,32'h0);

        @(negedge clk);
        #1 check("reset_outputs", outs(), 99'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            ecall_i = tbl[i].ec; ebreak_i = tbl[i].eb; mret_i = tbl[i].mr;
            timer_int_i = tbl[i].ti; global_int_en_i = tbl[i].ge; wbu_csr_we_i = tbl[i].wb;
            inst_addr_i = tbl[i].pc; csr_mstatus_i = tbl[i].ms;
            csr_mtvec_i = tbl[i].tv; csr_mepc_i = tbl[i].ep;
            #1 check($sformatf("vec%0d", i), outs(),
                     {tbl[i].hold, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].as, tbl[i].ia});
        end

        // reset asserted while in W_MSTATUS
        @(negedge clk);
        idle_inputs();
        ecall_i = 1; inst_addr_i = 32'h900; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h100;
        @(negedge clk);
        ecall_i = 0;
        #1 check("rst_seq_mepc", outs(), {1'b1, 1'b1, 32'h341, 32'h900, 1'b0, 32'h0});
        @(negedge clk);
        #1 check("rst_seq_mstatus", outs(), {1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0});
        rst_n = 1'b0;
        #1 check("rst_mid_outputs", outs(), 99'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 check($sformatf("post_rst_idle%0d", k), outs(), 99'h0);
        end
        @(negedge clk);
        mret_i = 1; csr_mstatus_i = 32'h0; csr_mepc_i = 32'h44;
        @(negedge clk);
        mret_i = 0;
        #1 check("post_rst_mret", outs(), {1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0});
        @(negedge clk);
        #1 check("post_rst_assert", outs(), {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 32'h44});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
